sequence_checker: RTL and testbench
===================================

# sequence_checker

Round engine feeding the game state controller. It generates a random 9-step pattern, plays the first `current_level+1` steps on the LEDs, and checks the player's debounced switch presses against that prefix. It issues one-cycle `level_complete` or `game_over_signal` pulses to the controller and reads back `current_state` and `current_level` from it.

## Interface
- `SHOW_CYCLES`, default 12_500_000: cycles each pattern LED stays lit.
- `GAP_CYCLES`, default 6_250_000: dark cycles before each step.
- `TIMEOUT_CYCLES`, default 125_000_000: input idle limit; used only with the macro.
- `LFSR_SEED`, default 16'hACE1: non-zero LFSR reset value.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `current_state`  in  2  controller state: 00 RESET, 01 LEVEL_INCREMENT, 10 GAME_OVER, 11 WINNING_SCREEN.
- `current_level`  in  4  controller level, 0..8.
- `press_valid`  in  1  one-cycle pulse, one debounced press.
- `press_id`  in  2  switch index 0..3; qualified by `press_valid`.
- `led`  out  4  one-hot pattern display.
- `playing`  out  1  high in FILL/SHOW_OFF/SHOW_ON.
- `awaiting_input`  out  1  high in INPUT.
- `level_complete`  out  1  one-cycle pulse, round passed.
- `game_over_signal`  out  1  one-cycle pulse, round failed.

## Operation
- Round length is `len = min(current_level,8)+1`, sampled at round start.
- The pattern is 9 entries × 2 bits. The LFSR (x^16+x^14+x^13+x^11+1) advances every cycle from reset.
- **Round start:** `current_state`==01 this cycle and not 01 last cycle. The previous state register resets to 00.
- FSM states: IDLE, FILL, SHOW_OFF, SHOW_ON, INPUT, DONE.
  - IDLE: wait for round start. Go to FILL if `current_level`==0, otherwise go to SHOW_OFF with idx=0.
  - FILL: 9 cycles. Entry[idx] = lfsr[1:0]. Then go to SHOW_OFF, idx=0.
  - SHOW_OFF: `led`=0 for GAP_CYCLES, then go to SHOW_ON.
  - SHOW_ON: `led`=1<<entry[idx] for SHOW_CYCLES. Then, if idx==len-1, go to INPUT with idx=0; otherwise idx+1 and go to SHOW_OFF.
  - INPUT: on `press_valid`, compare `press_id` with entry[idx].
    - Match and idx==len-1: pulse `level_complete`, go to DONE.
    - Match otherwise: idx+1.
    - Mismatch: pulse `game_over_signal`, go to DONE.
  - DONE: outputs idle. Go to IDLE when `current_state`≠01.
- Presses outside INPUT are ignored.
- **Abort:** `current_state`≠01 in FILL/SHOW/INPUT sends the FSM to IDLE with no pulse. Abort has priority over any press that cycle.
- The pattern is held across rounds; only a level-0 round start refills it.
- At most one pulse per round. `level_complete` and `game_over_signal` are never high together.

## Timing
- Reset values: FSM=IDLE, idx=0, timer=0, lfsr=LFSR_SEED, pattern=0, all outputs 0.
- FILL → SHOW_OFF takes exactly 9 cycles.
- Round start to first LED lit:
  - Level 0: 1+9+GAP_CYCLES cycles.
  - Level >0: 1+GAP_CYCLES cycles.
- Pulses are registered and appear the cycle after the deciding `press_valid`.
- `awaiting_input` drops in the same cycle the pulse rises.
- Back-to-back presses on consecutive cycles are each evaluated.
- The timer counts 0..N-1. Its width is clog2 of the largest enabled parameter.

## Configuration
- `INPUT_TIMEOUT_EN` defined:
  - An idle counter runs in INPUT and clears on entry and on each accepted press.
  - Reaching TIMEOUT_CYCLES-1 pulses `game_over_signal` and goes to DONE.
  - A press in the same cycle as the timeout wins over the timeout.
- `INPUT_TIMEOUT_EN` undefined: INPUT waits indefinitely, and the counter and parameter are unused.

## Structure
- Shared `game_pkg`:
  - controller state encodings 00/01/10/11
  - `MAX_LEN`=9
  - step index width 4
  - FSM state enum
- Sub-module `lfsr16`: Galois LFSR with parameter SEED, advancing every cycle, exposing the 16-bit state. The checker uses bits [1:0].

## Test plan
Parameters: SHOW=4, GAP=2, TIMEOUT=50, macro on.
1. Level 0 round start: FILL lasts 9 cycles; `led` lights entry[0] after 2 dark cycles and stays lit 4 cycles. Correct press → `level_complete` 1 cycle later, width 1.
2. Level 3 with pattern 2,0,3,1,…: four steps show `led`=4,1,8,2. Press 2,0,3,1 → one `level_complete`. Press 2,0,1 → `game_over_signal` after the third press.
3. Presses during SHOW_ON/SHOW_OFF are ignored. `current_state`→10 mid-INPUT → IDLE, no pulse.
4. No press for 50 cycles in INPUT → `game_over_signal`. A press on cycle 49 that matches and is the last step → `level_complete` only.
5. Async `reset` mid-SHOW_ON → all outputs 0 immediately, lfsr=ACE1. A level-1 round afterwards reuses pattern 0 (no FILL).
6. Level 8 with all 9 presses correct → `level_complete`. `current_level`=12 is treated as len=9.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the game controller and its round engine.
// Controller states, pattern geometry and small display/length helpers.
package game_pkg;

   typedef enum logic [1:0] {
      CS_RESET     = 2'b00,
      CS_LEVEL_INC = 2'b01,
      CS_GAME_OVER = 2'b10,
      CS_WINNING   = 2'b11
   } ctrl_state_e;

   localparam int unsigned MAX_LEN = 9;
   localparam int unsigned IDX_W   = 4;

   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_SHOW_OFF,
      ST_SHOW_ON,
      ST_INPUT,
      ST_DONE
   } seq_state_e;

   function automatic logic [3:0] step_to_led(input logic [1:0] step);
      return 4'b0001 << step;
   endfunction

   // Levels beyond the pattern depth play the whole pattern.
   function automatic idx_t last_index(input logic [3:0] level);
      return (level > 4'd8) ? idx_t'(MAX_LEN - 1) : idx_t'(level);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, one step per cycle.
// State is registered; no handshake, never stalls.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] state_o
);

   localparam logic [15:0] TAPS = 16'hB400;

   logic [15:0] state_q;
   logic [15:0] state_d;

   always_comb begin
      state_d = {1'b0, state_q[15:1]};
      if (state_q[0]) begin
         state_d = state_d ^ TAPS;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/sequence_checker.sv
// Round engine: fills/plays a 9-step pattern prefix, checks presses, pulses pass/fail one cycle after the deciding press.
// Presses are only consumed in INPUT; INPUT_TIMEOUT_EN adds an idle limit that fails the round.
module sequence_checker
   import game_pkg::*;
#(
   parameter int unsigned SHOW_CYCLES    = 12_500_000,
   parameter int unsigned GAP_CYCLES     = 6_250_000,
   parameter int unsigned TIMEOUT_CYCLES = 125_000_000,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] current_state,
   input  logic [3:0] current_level,
   input  logic       press_valid,
   input  logic [1:0] press_id,
   output logic [3:0] led,
   output logic       playing,
   output logic       awaiting_input,
   output logic       level_complete,
   output logic       game_over_signal
);

   localparam int unsigned SG_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
`ifdef INPUT_TIMEOUT_EN
   localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > SG_MAX) ? TIMEOUT_CYCLES : SG_MAX;
`else
   localparam int unsigned TMR_MAX = SG_MAX;
`endif
   localparam int unsigned TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   typedef logic [TMR_W-1:0] tmr_t;

   localparam tmr_t GAP_LAST  = tmr_t'(GAP_CYCLES - 1);
   localparam tmr_t SHOW_LAST = tmr_t'(SHOW_CYCLES - 1);
`ifdef INPUT_TIMEOUT_EN
   localparam tmr_t TMO_LAST  = tmr_t'(TIMEOUT_CYCLES - 1);
`endif

   logic [15:0] lfsr_state;

   lfsr16 #(
      .SEED    (LFSR_SEED)
   ) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .state_o (lfsr_state)
   );

   seq_state_e  state_q;
   idx_t        idx_q;
   idx_t        last_q;
   tmr_t        timer_q;
   logic [1:0]  prev_cs_q;
   logic [1:0]  pattern_q [MAX_LEN];
   logic [3:0]  led_q;
   logic        playing_q;
   logic        awaiting_q;
   logic        lc_q;
   logic        go_q;

   logic        in_round;
   logic        round_start;
   logic        abort;
   logic        press_match;

   assign in_round    = (current_state == CS_LEVEL_INC);
   assign round_start = in_round && (prev_cs_q != CS_LEVEL_INC);
   assign abort       = !in_round && (state_q inside {ST_FILL, ST_SHOW_OFF, ST_SHOW_ON, ST_INPUT});
   assign press_match = (press_id == pattern_q[idx_q]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         last_q     <= '0;
         timer_q    <= '0;
         prev_cs_q  <= CS_RESET;
         for (int i = 0; i < MAX_LEN; i++) begin
            pattern_q[i] <= 2'b00;
         end
         led_q      <= 4'b0000;
         playing_q  <= 1'b0;
         awaiting_q <= 1'b0;
         lc_q       <= 1'b0;
         go_q       <= 1'b0;
      end else begin
         prev_cs_q <= current_state;
         lc_q      <= 1'b0;
         go_q      <= 1'b0;

         // Abort outranks any press seen in the same cycle.
         if (abort) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            timer_q    <= '0;
            led_q      <= 4'b0000;
            playing_q  <= 1'b0;
            awaiting_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (round_start) begin
                     last_q    <= last_index(current_level);
                     idx_q     <= '0;
                     timer_q   <= '0;
                     playing_q <= 1'b1;
                     state_q   <= (current_level == 4'd0) ? ST_FILL : ST_SHOW_OFF;
                  end
               end

               ST_FILL: begin
                  pattern_q[idx_q] <= lfsr_state[1:0];
                  if (idx_q == idx_t'(MAX_LEN - 1)) begin
                     idx_q   <= '0;
                     state_q <= ST_SHOW_OFF;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end

               ST_SHOW_OFF: begin
                  if (timer_q == GAP_LAST) begin
                     timer_q <= '0;
                     led_q   <= step_to_led(pattern_q[idx_q]);
                     state_q <= ST_SHOW_ON;
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end

               ST_SHOW_ON: begin
                  if (timer_q == SHOW_LAST) begin
                     timer_q <= '0;
                     led_q   <= 4'b0000;
                     if (idx_q == last_q) begin
                        idx_q      <= '0;
                        playing_q  <= 1'b0;
                        awaiting_q <= 1'b1;
                        state_q    <= ST_INPUT;
                     end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ST_SHOW_OFF;
                     end
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end

               ST_INPUT: begin
                  if (press_valid) begin
                     timer_q <= '0;
                     if (press_match && (idx_q != last_q)) begin
                        idx_q <= idx_q + 1'b1;
                     end else begin
                        lc_q       <= press_match;
                        go_q       <= !press_match;
                        idx_q      <= '0;
                        awaiting_q <= 1'b0;
                        state_q    <= ST_DONE;
                     end
                  end
`ifdef INPUT_TIMEOUT_EN
                  else if (timer_q == TMO_LAST) begin
                     timer_q    <= '0;
                     go_q       <= 1'b1;
                     idx_q      <= '0;
                     awaiting_q <= 1'b0;
                     state_q    <= ST_DONE;
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
`endif
               end

               ST_DONE: begin
                  if (!in_round) begin
                     state_q <= ST_IDLE;
                  end
               end

               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign led              = led_q;
   assign playing          = playing_q;
   assign awaiting_input   = awaiting_q;
   assign level_complete   = lc_q;
   assign game_over_signal = go_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker with SHOW=4, GAP=2, TIMEOUT=50.
// The pattern is predicted from a reference LFSR tracking the DUT from reset.
module tb_sequence_checker;

   localparam int SHOW = 4;
   localparam int GAP  = 2;
   localparam int TMO  = 50;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] current_state = 2'b00;
   logic [3:0] current_level = 4'd0;
   logic       press_valid = 1'b0;
   logic [1:0] press_id = 2'b00;
   logic [3:0] led;
   logic       playing;
   logic       awaiting_input;
   logic       level_complete;
   logic       game_over_signal;

   sequence_checker #(
      .SHOW_CYCLES    (SHOW),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO),
      .LFSR_SEED      (16'hACE1)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .current_state    (current_state),
      .current_level    (current_level),
      .press_valid      (press_valid),
      .press_id         (press_id),
      .led              (led),
      .playing          (playing),
      .awaiting_input   (awaiting_input),
      .level_complete   (level_complete),
      .game_over_signal (game_over_signal)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int lc_cnt = 0;
   int go_cnt = 0;
   int both_cnt = 0;

   logic [15:0] m_lfsr;
   logic [1:0]  exp_pat [9];

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic [15:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) m_lfsr <= 16'hACE1;
      else       m_lfsr <= lfsr_next(m_lfsr);
   end

   always @(negedge clk) begin
      if (level_complete) lc_cnt++;
      if (game_over_signal) go_cnt++;
      if (level_complete && game_over_signal) both_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic press(input logic [1:0] id);
      press_valid = 1'b1;
      press_id    = id;
      tick();
      press_valid = 1'b0;
   endtask

   task automatic start_round(input logic [3:0] lvl);
      current_level = lvl;
      current_state = 2'b01;
      tick();
   endtask

   task automatic end_round();
      current_state = 2'b00;
      tick();
      tick();
   endtask

   // Level-0 round start; records what FILL writes. Returns in the last FILL cycle.
   task automatic start_fill_round();
      start_round(4'd0);
      for (int k = 0; k < 9; k++) begin
         exp_pat[k] = m_lfsr[1:0];
         if (k < 8) tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (led !== 4'b0000 || playing !== 1'b0 || awaiting_input !== 1'b0 ||
          level_complete !== 1'b0 || game_over_signal !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: led=%b play=%b await=%b lc=%b go=%b, required all 0",
                  led, playing, awaiting_input, level_complete, game_over_signal);
      end
      checks++;
      if (dut.lfsr_state !== 16'hACE1) begin
         errors++;
         $display("FAIL reset_lfsr: got %h required ace1", dut.lfsr_state);
      end
      reset = 1'b0;
      for (int i = 0; i < 9; i++) exp_pat[i] = 2'b00;
      tick();
      checks++;
      if (dut.lfsr_state !== 16'hE270) begin
         errors++;
         $display("FAIL lfsr_step1: got %h required e270", dut.lfsr_state);
      end
      tick();
      checks++;
      if (dut.lfsr_state !== 16'h7138) begin
         errors++;
         $display("FAIL lfsr_step2: got %h required 7138", dut.lfsr_state);
      end
      checks++;
      if (playing !== 1'b0 || led !== 4'b0000) begin
         errors++;
         $display("FAIL idle_outputs: play=%b led=%b required 0/0000", playing, led);
      end
   endtask

   task automatic test_level0();
      int lc0;
      lc0 = lc_cnt;
      start_fill_round();
      checks++;
      if (playing !== 1'b1 || led !== 4'b0000) begin
         errors++;
         $display("FAIL fill_outputs: play=%b led=%b required 1/0000", playing, led);
      end
      for (int g = 0; g < GAP; g++) begin
         tick();
         checks++;
         if (led !== 4'b0000) begin
            errors++;
            $display("FAIL l0_dark cycle %0d: led=%b required 0000", g, led);
         end
      end
      tick();
      for (int h = 0; h < SHOW; h++) begin
         checks++;
         if (led !== (4'b0001 << exp_pat[0])) begin
            errors++;
            $display("FAIL l0_lit cycle %0d: led=%b required %b", h, led, 4'b0001 << exp_pat[0]);
         end
         tick();
      end
      checks++;
      if (led !== 4'b0000 || awaiting_input !== 1'b1 || playing !== 1'b0) begin
         errors++;
         $display("FAIL l0_input_entry: led=%b await=%b play=%b required 0000/1/0",
                  led, awaiting_input, playing);
      end
      press(exp_pat[0]);
      checks++;
      if (level_complete !== 1'b1 || awaiting_input !== 1'b0 || game_over_signal !== 1'b0) begin
         errors++;
         $display("FAIL l0_pass_pulse: lc=%b await=%b go=%b required 1/0/0",
                  level_complete, awaiting_input, game_over_signal);
      end
      tick();
      checks++;
      if (level_complete !== 1'b0 || lc_cnt - lc0 != 1) begin
         errors++;
         $display("FAIL l0_pulse_width: lc=%b pulses=%0d required 0/1", level_complete, lc_cnt - lc0);
      end
      end_round();
   endtask

   task automatic test_show_ignore();
      int lc0, go0;
      lc0 = lc_cnt;
      go0 = go_cnt;
      start_round(4'd3);
      for (int s = 0; s < 4; s++) begin
         for (int g = 0; g < GAP; g++) begin
            checks++;
            if (led !== 4'b0000) begin
               errors++;
               $display("FAIL l3_dark step %0d: led=%b required 0000", s, led);
            end
            press_valid = (g == 0);
            press_id    = ~exp_pat[s];
            tick();
         end
         for (int h = 0; h < SHOW; h++) begin
            checks++;
            if (led !== (4'b0001 << exp_pat[s])) begin
               errors++;
               $display("FAIL l3_lit step %0d: led=%b required %b", s, led, 4'b0001 << exp_pat[s]);
            end
            press_valid = (h == SHOW - 1);
            press_id    = ~exp_pat[s];
            tick();
         end
      end
      press_valid = 1'b0;
      checks++;
      if (awaiting_input !== 1'b1 || go_cnt != go0) begin
         errors++;
         $display("FAIL show_press_ignored: await=%b go_pulses=%0d required 1/0", awaiting_input, go_cnt - go0);
      end
      for (int i = 0; i < 3; i++) begin
         press(exp_pat[i]);
         checks++;
         if (awaiting_input !== 1'b1 || level_complete !== 1'b0) begin
            errors++;
            $display("FAIL l3_mid_press %0d: await=%b lc=%b required 1/0", i, awaiting_input, level_complete);
         end
      end
      press(exp_pat[3]);
      checks++;
      if (level_complete !== 1'b1 || game_over_signal !== 1'b0 || awaiting_input !== 1'b0) begin
         errors++;
         $display("FAIL l3_pass: lc=%b go=%b await=%b required 1/0/0",
                  level_complete, game_over_signal, awaiting_input);
      end
      tick();
      checks++;
      if (lc_cnt - lc0 != 1 || go_cnt != go0) begin
         errors++;
         $display("FAIL l3_pulse_count: lc=%0d go=%0d required 1/0", lc_cnt - lc0, go_cnt - go0);
      end
      end_round();
   endtask

   task automatic test_fail();
      int lc0, go0;
      lc0 = lc_cnt;
      go0 = go_cnt;
      start_round(4'd3);
      run_cycles(4 * (GAP + SHOW));
      press(exp_pat[0]);
      press(exp_pat[1]);
      checks++;
      if (game_over_signal !== 1'b0 || awaiting_input !== 1'b1) begin
         errors++;
         $display("FAIL fail_early: go=%b await=%b required 0/1", game_over_signal, awaiting_input);
      end
      press(exp_pat[2] ^ 2'b01);
      checks++;
      if (game_over_signal !== 1'b1 || level_complete !== 1'b0 || awaiting_input !== 1'b0) begin
         errors++;
         $display("FAIL fail_pulse: go=%b lc=%b await=%b required 1/0/0",
                  game_over_signal, level_complete, awaiting_input);
      end
      tick();
      press(exp_pat[3]);
      tick();
      checks++;
      if (go_cnt - go0 != 1 || lc_cnt != lc0) begin
         errors++;
         $display("FAIL fail_pulse_count: go=%0d lc=%0d required 1/0", go_cnt - go0, lc_cnt - lc0);
      end
      end_round();
   endtask

   task automatic test_abort();
      int lc0, go0;
      lc0 = lc_cnt;
      go0 = go_cnt;
      start_round(4'd2);
      run_cycles(3 * (GAP + SHOW));
      press(exp_pat[0]);
      current_state = 2'b10;
      press_valid   = 1'b1;
      press_id      = ~exp_pat[1];
      tick();
      press_valid = 1'b0;
      checks++;
      if (awaiting_input !== 1'b0 || playing !== 1'b0 || game_over_signal !== 1'b0 || level_complete !== 1'b0) begin
         errors++;
         $display("FAIL abort_outputs: await=%b play=%b go=%b lc=%b required all 0",
                  awaiting_input, playing, game_over_signal, level_complete);
      end
      run_cycles(3);
      checks++;
      if (go_cnt != go0 || lc_cnt != lc0) begin
         errors++;
         $display("FAIL abort_no_pulse: go=%0d lc=%0d required 0/0", go_cnt - go0, lc_cnt - lc0);
      end
      end_round();
   endtask

`ifdef INPUT_TIMEOUT_EN
   task automatic test_timeout();
      int lc0, go0;
      go0 = go_cnt;
      start_round(4'd1);
      run_cycles(2 * (GAP + SHOW));
      run_cycles(TMO - 1);
      checks++;
      if (awaiting_input !== 1'b1 || go_cnt != go0) begin
         errors++;
         $display("FAIL tmo_early: await=%b go=%0d required 1/0", awaiting_input, go_cnt - go0);
      end
      tick();
      checks++;
      if (game_over_signal !== 1'b1 || awaiting_input !== 1'b0) begin
         errors++;
         $display("FAIL tmo_fire: go=%b await=%b required 1/0", game_over_signal, awaiting_input);
      end
      end_round();
      lc0 = lc_cnt;
      go0 = go_cnt;
      start_round(4'd1);
      run_cycles(2 * (GAP + SHOW));
      press(exp_pat[0]);
      run_cycles(TMO - 1);
      press(exp_pat[1]);
      checks++;
      if (level_complete !== 1'b1 || game_over_signal !== 1'b0) begin
         errors++;
         $display("FAIL tmo_press_wins: lc=%b go=%b required 1/0", level_complete, game_over_signal);
      end
      tick();
      checks++;
      if (lc_cnt - lc0 != 1 || go_cnt != go0) begin
         errors++;
         $display("FAIL tmo_press_count: lc=%0d go=%0d required 1/0", lc_cnt - lc0, go_cnt - go0);
      end
      end_round();
   endtask
`else
   task automatic test_timeout();
      int lc0, go0;
      lc0 = lc_cnt;
      go0 = go_cnt;
      start_round(4'd1);
      run_cycles(2 * (GAP + SHOW));
      run_cycles(TMO + 10);
      checks++;
      if (awaiting_input !== 1'b1 || go_cnt != go0) begin
         errors++;
         $display("FAIL no_timeout_wait: await=%b go=%0d required 1/0", awaiting_input, go_cnt - go0);
      end
      press(exp_pat[0]);
      press(exp_pat[1]);
      checks++;
      if (level_complete !== 1'b1 || lc_cnt != lc0) begin
         errors++;
         $display("FAIL no_timeout_pass: lc=%b prior=%0d required 1/0", level_complete, lc_cnt - lc0);
      end
      end_round();
   endtask
`endif

   task automatic test_reset_mid_show();
      int lc0;
      start_round(4'd1);
      run_cycles(GAP);
      checks++;
      if (led !== (4'b0001 << exp_pat[0])) begin
         errors++;
         $display("FAIL pre_reset_lit: led=%b required %b", led, 4'b0001 << exp_pat[0]);
      end
      reset = 1'b1;
      current_state = 2'b00;
      #1;
      checks++;
      if (led !== 4'b0000 || playing !== 1'b0 || awaiting_input !== 1'b0 ||
          level_complete !== 1'b0 || game_over_signal !== 1'b0 || dut.lfsr_state !== 16'hACE1) begin
         errors++;
         $display("FAIL async_reset: led=%b play=%b await=%b lfsr=%h required 0000/0/0/ace1",
                  led, playing, awaiting_input, dut.lfsr_state);
      end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 9; i++) exp_pat[i] = 2'b00;
      tick();
      lc0 = lc_cnt;
      start_round(4'd1);
      run_cycles(GAP - 1);
      checks++;
      if (led !== 4'b0000 || playing !== 1'b1) begin
         errors++;
         $display("FAIL no_fill_dark: led=%b play=%b required 0000/1", led, playing);
      end
      tick();
      checks++;
      if (led !== 4'b0001) begin
         errors++;
         $display("FAIL no_fill_lit: led=%b required 0001", led);
      end
      run_cycles(SHOW + GAP + SHOW);
      press(2'd0);
      press(2'd0);
      checks++;
      if (level_complete !== 1'b1 || lc_cnt != lc0) begin
         errors++;
         $display("FAIL zero_pattern_pass: lc=%b prior=%0d required 1/0", level_complete, lc_cnt - lc0);
      end
      end_round();
   endtask

   task automatic test_level8();
      int lc0;
      start_fill_round();
      run_cycles(1 + GAP + SHOW);
      press(exp_pat[0]);
      end_round();
      // Level 8, presses on consecutive cycles.
      lc0 = lc_cnt;
      start_round(4'd8);
      run_cycles(9 * (GAP + SHOW));
      checks++;
      if (awaiting_input !== 1'b1) begin
         errors++;
         $display("FAIL l8_input_entry: await=%b required 1", awaiting_input);
      end
      for (int i = 0; i < 9; i++) begin
         press_valid = 1'b1;
         press_id    = exp_pat[i];
         tick();
         if (i < 8) begin
            checks++;
            if (level_complete !== 1'b0 || awaiting_input !== 1'b1) begin
               errors++;
               $display("FAIL b2b_press %0d: lc=%b await=%b required 0/1", i, level_complete, awaiting_input);
            end
         end
      end
      press_valid = 1'b0;
      checks++;
      if (level_complete !== 1'b1 || lc_cnt != lc0) begin
         errors++;
         $display("FAIL l8_pass: lc=%b prior=%0d required 1/0", level_complete, lc_cnt - lc0);
      end
      end_round();
      lc0 = lc_cnt;
      start_round(4'd12);
      run_cycles(9 * (GAP + SHOW));
      for (int i = 0; i < 8; i++) press(exp_pat[i]);
      checks++;
      if (awaiting_input !== 1'b1 || lc_cnt != lc0) begin
         errors++;
         $display("FAIL l12_len: await=%b lc=%0d required 1/0", awaiting_input, lc_cnt - lc0);
      end
      press(exp_pat[8]);
      checks++;
      if (level_complete !== 1'b1) begin
         errors++;
         $display("FAIL l12_pass: lc=%b required 1", level_complete);
      end
      end_round();
   endtask

   initial begin
      test_reset();
      test_level0();
      test_show_ignore();
      test_fail();
      test_abort();
      test_timeout();
      test_reset_mid_show();
      test_level8();
      checks++;
      if (both_cnt != 0) begin
         errors++;
         $display("FAIL exclusive_pulses: both high %0d cycles, required 0", both_cnt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
